// File: rtl/fifo_wptr_full.sv
// Write-side pointer and full/level logic for an asynchronous FIFO.
// It keeps a binary write pointer, publishes it in Gray code, and flags full/almost-full against the synchronized read pointer.
module fifo_wptr_full #(
  parameter int ADDR_SIZE    = 4,
  parameter int AFULL_THRESH = 12
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 wr_en,
  input  logic [ADDR_SIZE:0]   rd_ptr_gray_sync,
  output logic                 wr_accept,
  output logic [ADDR_SIZE-1:0] wr_addr,
  output logic [ADDR_SIZE:0]   wr_ptr_gray,
  output logic                 full,
  output logic                 almost_full,
  output logic [ADDR_SIZE:0]   fill_level,
  output logic                 overflow
);

  localparam int PW = ADDR_SIZE + 1;
  localparam logic [PW-1:0] AF_TH = PW'(AFULL_THRESH);

  function automatic logic [PW-1:0] bin2gray(input logic [PW-1:0] b);
    return b ^ (b >> 1);
  endfunction

  function automatic logic [PW-1:0] gray2bin(input logic [PW-1:0] g);
    logic [PW-1:0] b;
    b[PW-1] = g[PW-1];
    for (int i = PW - 2; i >= 0; i--) begin
      b[i] = b[i+1] ^ g[i];
    end
    return b;
  endfunction

  logic [PW-1:0] r_wbin;
  logic [PW-1:0] r_wgray;
  logic          r_full;
  logic          r_afull;
  logic [PW-1:0] r_level;
  logic          r_ovf;

  logic [PW-1:0] w_wbin_next;
  logic [PW-1:0] w_wgray_next;
  logic [PW-1:0] w_rbin;
  logic [PW-1:0] w_level_next;
  logic [PW-1:0] w_full_gray;
  logic          w_accept;

  assign w_accept     = wr_en & ~r_full;
  assign w_wbin_next  = r_wbin + {{ADDR_SIZE{1'b0}}, w_accept};
  assign w_wgray_next = bin2gray(w_wbin_next);
  assign w_rbin       = gray2bin(rd_ptr_gray_sync);
  // Modulo subtraction keeps the level correct across pointer wrap.
  assign w_level_next = w_wbin_next - w_rbin;
  // Full in Gray space: top two bits inverted, remainder equal.
  assign w_full_gray  = {~rd_ptr_gray_sync[PW-1:PW-2], rd_ptr_gray_sync[PW-3:0]};

  always_ff @(posedge clk) begin
    if (rst) begin
      r_wbin  <= '0;
      r_wgray <= '0;
      r_full  <= 1'b0;
      r_afull <= 1'b0;
      r_level <= '0;
      r_ovf   <= 1'b0;
    end else begin
      r_wbin  <= w_wbin_next;
      r_wgray <= w_wgray_next;
      r_full  <= (w_wgray_next == w_full_gray);
      r_afull <= (w_level_next >= AF_TH);
      r_level <= w_level_next;
      if (wr_en && r_full) begin
        r_ovf <= 1'b1;
      end
    end
  end

  assign wr_accept   = w_accept;
  assign wr_addr     = r_wbin[ADDR_SIZE-1:0];
  assign wr_ptr_gray = r_wgray;
  assign full        = r_full;
  assign almost_full = r_afull;
  assign fill_level  = r_level;
  assign overflow    = r_ovf;

endmodule

// File: tb/tb_fifo_wptr_full.sv
// Directed bench for fifo_wptr_full: fill, overflow, read release, same-cycle read/write, wrap and reset-under-load.
module tb_fifo_wptr_full;

  logic       clk = 1'b0;
  logic       rst;
  logic       wr_en;
  logic [4:0] rd_ptr_gray_sync;
  logic       wr_accept;
  logic [3:0] wr_addr;
  logic [4:0] wr_ptr_gray;
  logic       full;
  logic       almost_full;
  logic [4:0] fill_level;
  logic       overflow;

  int n_checks = 0;
  int n_fail   = 0;

  fifo_wptr_full #(.ADDR_SIZE(4), .AFULL_THRESH(12)) dut (
    .clk              (clk),
    .rst              (rst),
    .wr_en            (wr_en),
    .rd_ptr_gray_sync (rd_ptr_gray_sync),
    .wr_accept        (wr_accept),
    .wr_addr          (wr_addr),
    .wr_ptr_gray      (wr_ptr_gray),
    .full             (full),
    .almost_full      (almost_full),
    .fill_level       (fill_level),
    .overflow         (overflow)
  );

  always #5 clk = ~clk;

  // Gray codes of write-pointer values 1..16 in order.
  logic [4:0] fill_gray [16] = '{5'h01, 5'h03, 5'h02, 5'h06, 5'h07, 5'h05, 5'h04, 5'h0C,
                                 5'h0D, 5'h0F, 5'h0E, 5'h0A, 5'h0B, 5'h09, 5'h08, 5'h18};

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [4:0] gray_of(input int v);
    logic [4:0] b;
    b = 5'(v);
    return b ^ (b >> 1);
  endfunction

  logic [4:0] prev_gray;

  initial begin
    rst = 1'b1;
    wr_en = 1'b0;
    rd_ptr_gray_sync = 5'h00;
    tick();
    tick();
    check("rst_gray", 32'(wr_ptr_gray), 32'h0);
    check("rst_full", 32'(full), 32'h0);
    check("rst_afull", 32'(almost_full), 32'h0);
    check("rst_level", 32'(fill_level), 32'h0);
    check("rst_ovf", 32'(overflow), 32'h0);
    check("rst_addr", 32'(wr_addr), 32'h0);
    rst = 1'b0;

    // Fill 16 entries with the reader parked at zero.
    for (int i = 0; i < 16; i++) begin
      wr_en = 1'b1;
      #1;
      check("fill_accept", 32'(wr_accept), 32'h1);
      check("fill_addr", 32'(wr_addr), 32'(i));
      tick();
      check("fill_gray", 32'(wr_ptr_gray), 32'(fill_gray[i]));
      check("fill_level", 32'(fill_level), 32'(i + 1));
      check("fill_afull", 32'(almost_full), (i + 1 >= 12) ? 32'h1 : 32'h0);
      check("fill_full", 32'(full), (i == 15) ? 32'h1 : 32'h0);
    end

    // Writes while full are dropped and latch overflow.
    for (int i = 0; i < 3; i++) begin
      #1;
      check("ovf_accept", 32'(wr_accept), 32'h0);
      tick();
      check("ovf_gray", 32'(wr_ptr_gray), 32'h18);
      check("ovf_flag", 32'(overflow), 32'h1);
      check("ovf_level", 32'(fill_level), 32'd16);
    end
    wr_en = 1'b0;
    tick();
    check("ovf_sticky", 32'(overflow), 32'h1);

    // One read frees a slot; one write refills it.
    rd_ptr_gray_sync = 5'h01;
    tick();
    check("rel_full", 32'(full), 32'h0);
    check("rel_level", 32'(fill_level), 32'd15);
    wr_en = 1'b1;
    #1;
    check("rel_accept", 32'(wr_accept), 32'h1);
    check("rel_addr", 32'(wr_addr), 32'h0);
    tick();
    wr_en = 1'b0;
    check("refill_full", 32'(full), 32'h1);
    check("refill_level", 32'(fill_level), 32'd16);
    check("refill_gray", 32'(wr_ptr_gray), 32'h19);

    // Level 12, then a write and a read in the same cycle.
    rd_ptr_gray_sync = 5'h07;
    tick();
    check("l12_level", 32'(fill_level), 32'd12);
    check("l12_afull", 32'(almost_full), 32'h1);
    check("l12_full", 32'(full), 32'h0);
    wr_en = 1'b1;
    rd_ptr_gray_sync = 5'h05;
    tick();
    wr_en = 1'b0;
    check("rw_level", 32'(fill_level), 32'd12);
    check("rw_afull", 32'(almost_full), 32'h1);
    check("rw_gray", 32'(wr_ptr_gray), 32'h1B);

    // Wrap: fresh start, prefill 5, then 40 writes with the reader 5 behind.
    rst = 1'b1;
    rd_ptr_gray_sync = 5'h00;
    tick();
    rst = 1'b0;
    check("wrap_rst_ovf", 32'(overflow), 32'h0);
    wr_en = 1'b1;
    for (int i = 0; i < 5; i++) tick();
    check("wrap_pre_level", 32'(fill_level), 32'd5);
    for (int j = 0; j < 40; j++) begin
      prev_gray = wr_ptr_gray;
      rd_ptr_gray_sync = gray_of(j + 1);
      tick();
      check("wrap_level", 32'(fill_level), 32'd5);
      check("wrap_onebit", 32'($countones(prev_gray ^ wr_ptr_gray)), 32'd1);
      check("wrap_gray", 32'(wr_ptr_gray), 32'(gray_of((6 + j) % 32)));
      if (j == 26) check("wrap_zero", 32'(wr_ptr_gray), 32'h0);
    end
    wr_en = 1'b0;
    check("wrap_end_gray", 32'(wr_ptr_gray), 32'h0B);
    check("wrap_full", 32'(full), 32'h0);
    check("wrap_ovf", 32'(overflow), 32'h0);

    // Reset under load: level 9 with overflow set.
    rst = 1'b1;
    rd_ptr_gray_sync = 5'h00;
    tick();
    rst = 1'b0;
    wr_en = 1'b1;
    for (int i = 0; i < 17; i++) tick();
    check("pre_full", 32'(full), 32'h1);
    check("pre_ovf", 32'(overflow), 32'h1);
    wr_en = 1'b0;
    rd_ptr_gray_sync = 5'h04;
    tick();
    check("pre_level", 32'(fill_level), 32'd9);
    rst = 1'b1;
    wr_en = 1'b1;
    rd_ptr_gray_sync = 5'h00;
    tick();
    check("lr_gray", 32'(wr_ptr_gray), 32'h0);
    check("lr_full", 32'(full), 32'h0);
    check("lr_afull", 32'(almost_full), 32'h0);
    check("lr_level", 32'(fill_level), 32'h0);
    check("lr_ovf", 32'(overflow), 32'h0);
    check("lr_addr", 32'(wr_addr), 32'h0);
    check("lr_accept", 32'(wr_accept), 32'h1);
    rst = 1'b0;
    wr_en = 1'b0;
    tick();

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
